btn_debounce_multi: RTL and testbench
=====================================

Name: btn_debounce_multi

Overview:
Parametrised multi-channel button conditioner. It replaces the single-channel shift-register debouncer with the following features:
- a per-channel input synchroniser
- a counter-based stability filter that works in both directions (press and release)
- one-cycle press and release pulses
- a long-press hold flag
It sits between the board push-buttons/switches and the lab control FSMs, one instance per button bank.

Parameters:
N_CH, 5, number of independent button channels
SYNC_STAGES, 2, synchroniser flop depth per channel (legal: >=2)
STABLE_CYCLES, 1000000, consecutive cycles the synchronised input must differ from btn_status before btn_status flips (10 ms at 100 MHz; legal: >=1)
HOLD_CYCLES, 100000000, consecutive cycles btn_status must be 1 before btn_hold asserts (1 s at 100 MHz; legal: >=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
btn_in  input  N_CH  raw asynchronous button levels, bit i = channel i
btn_status  output  N_CH  debounced level per channel
btn_press  output  N_CH  one-cycle pulse on a debounced 0->1 transition
btn_release  output  N_CH  one-cycle pulse on a debounced 1->0 transition
btn_hold  output  N_CH  level; 1 while the channel has been pressed for at least HOLD_CYCLES

Behaviour:
- Reset: the interface has one clock. Reset is asynchronous and active-low.
- rst_n low clears the following immediately, independent of clk:
  - all synchroniser flops, stability counters and hold counters
  - btn_status, btn_press, btn_release and btn_hold, all to 0
- Channels are fully independent. There is no shared state.
- Synchroniser: btn_in[i] passes through SYNC_STAGES flops. The last stage is sync[i].
- Stability filter, per channel, with counter width $clog2(STABLE_CYCLES+1):
  - sync == btn_status: the counter is cleared.
  - sync != btn_status and counter == STABLE_CYCLES-1: btn_status toggles and the counter clears.
  - otherwise the counter increments.
- Any bounce back to the btn_status value before the count completes restarts the count from 0.
- Latency: a clean step on btn_in changes btn_status exactly SYNC_STAGES+STABLE_CYCLES rising edges after the edge that first samples the new level. Rise and fall are symmetric.
- btn_press[i] is 1 in exactly the cycle in which btn_status[i] first reads 1, otherwise 0. btn_release[i] is the same for the first 0.
- btn_press and btn_release are registered together with btn_status. There is no extra latency and they never assert together on one channel.
- Hold counter, per channel, width $clog2(HOLD_CYCLES+1):
  - The counter is cleared while btn_status is 0.
  - It increments while btn_status is 1 and btn_hold is 0.
  - btn_hold sets on the edge where the counter reaches HOLD_CYCLES-1, i.e. HOLD_CYCLES cycles after btn_press.
  - After btn_hold sets, the counter saturates and btn_hold stays 1.
  - btn_hold clears in the same cycle btn_status falls (coincident with btn_release).
- No counter ever wraps. The stability counter cannot exceed STABLE_CYCLES-1, and the hold counter stops when btn_hold is set.
- Reset mid-count or mid-hold: all state is discarded. After rst_n rises, an input held at 1 produces btn_press after the full SYNC_STAGES+STABLE_CYCLES latency, and btn_hold HOLD_CYCLES later.
- Simultaneous events on different channels are handled in parallel with no arbitration.

Decomposition:
- Shared package btn_pkg holds:
  - CLK_HZ (100000000)
  - DEBOUNCE_MS (10) and HOLD_MS (1000)
  - derived cycle constants used as the top-level defaults
  - a function computing counter widths
- Sub-module btn_debounce_ch: one channel (synchroniser, stability counter, edge pulses, hold counter). It takes scalar ports and the same parameters minus N_CH.
- Top level btn_debounce_multi is a generate loop of N_CH instances.

Test Plan:
Bench parameters: N_CH=2, SYNC_STAGES=2, STABLE_CYCLES=4, HOLD_CYCLES=8.
- Reset check: rst_n=0 with btn_in=2'b11 held, then release -> all outputs 0 during reset. btn_status[1:0]=2'b11 and btn_press=2'b11 for one cycle on edge 6 after release. btn_hold=2'b11 8 cycles later.
- Clean press: btn_in[0] 0->1 -> btn_status[0]=1 and btn_press[0]=1 exactly 6 edges later. btn_press[0]=0 on the next cycle. Channel 1 unaffected.
- Bounce rejection: btn_in[0]=1 for 3 cycles, 0 for 1 cycle, then 1 steady -> no btn_press during the glitch. btn_status[0] rises 6 edges after the final rising sample.
- Release and hold: channel 0 pressed for 20 cycles after btn_status rises, then released -> btn_hold[0] rises 8 cycles after btn_press. On release, btn_status, btn_hold and btn_release[0] update in one cycle with btn_release a single-cycle pulse. A 3-cycle low glitch while pressed gives no release.
- Async reset mid-hold: assert rst_n low between clock edges while btn_hold[0]=1 -> all outputs 0 before the next edge. After release with btn_in held at 1, the full 6-cycle press latency is re-observed.
- Independence: opposite-phase bouncy stimulus on channels 0 and 1 -> each channel's outputs match the single-channel reference model cycle-for-cycle. No btn_press and btn_release on the same bit in the same cycle.

Source files
------------

// File: rtl/btn_pkg.sv
// btn_pkg: shared timing constants and counter-width helper for the button conditioner
package btn_pkg;
  localparam int CLK_HZ = 100_000_000;
  localparam int DEBOUNCE_MS = 10;
  localparam int HOLD_MS = 1000;
  localparam int STABLE_CYCLES_DEF = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int HOLD_CYCLES_DEF = CLK_HZ / 1000 * HOLD_MS;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one channel -- synchroniser, two-way stability filter, edge pulses, hold flag
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic status_o,
  output logic press_o,
  output logic release_o,
  output logic hold_o
);
  localparam int SW = cnt_w(STABLE_CYCLES);
  localparam int HW = cnt_w(HOLD_CYCLES);
  localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX = HW'(HOLD_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic status_q, status_d, press_q, press_d, release_q, release_d, hold_q, hold_d;
  logic sync, stab_done;
  assign sync = sync_q[SYNC_STAGES-1];
  always_comb begin
    stab_done = (sync != status_q) && (stab_q == S_MAX);
    status_d = status_q ^ stab_done;
    stab_d = (sync == status_q || stab_done) ? '0 : stab_q + 1'b1;
    press_d = status_d & ~status_q;
    release_d = ~status_d & status_q;
    // the hold counter saturates at H_MAX; hold drops together with status
    hold_d = status_d & (hold_q | (status_q & (hcnt_q == H_MAX)));
    hcnt_d = !status_d ? '0 : (status_q && !hold_q && hcnt_q != H_MAX) ? hcnt_q + 1'b1 : hcnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '0;
      stab_q <= '0;
      hcnt_q <= '0;
      status_q <= 1'b0;
      press_q <= 1'b0;
      release_q <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      stab_q <= stab_d;
      hcnt_q <= hcnt_d;
      status_q <= status_d;
      press_q <= press_d;
      release_q <= release_d;
      hold_q <= hold_d;
    end
  assign status_o = status_q;
  assign press_o = press_q;
  assign release_o = release_q;
  assign hold_o = hold_q;
endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: bank of independent button conditioners, one per channel
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int N_CH = 5,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_status,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_hold
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .btn_i(btn_in[i]),
      .status_o(btn_status[i]),
      .press_o(btn_press[i]),
      .release_o(btn_release[i]),
      .hold_o(btn_hold[i])
    );
  end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: directed checks of latency, bounce, hold, async reset and channel independence
module tb_btn_debounce_multi;
  localparam int SC = 4;
  localparam int HC = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] btn_in = 2'b00;
  logic [1:0] btn_status, btn_press, btn_release, btn_hold;
  int n_vec = 0;
  int n_err = 0;
  logic [1:0] m_s0, m_s1, m_st, m_pr, m_rl, m_hold;
  int m_run[2];
  int m_hc[2];
  always #5 clk = ~clk;
  btn_debounce_multi #(
    .N_CH(2),
    .SYNC_STAGES(2),
    .STABLE_CYCLES(SC),
    .HOLD_CYCLES(HC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_in(btn_in),
    .btn_status(btn_status),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .btn_hold(btn_hold)
  );
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic [1:0] v);
    btn_in = v;
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    logic [7:0] exp [5];
    int at [5];
    btn_in = 2'b11;
    rst_n = 1'b0;
    cyc(3);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'h00) begin
      n_err++;
      $display("FAIL reset_low: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'h00);
    end
    rst_n = 1'b1;
    exp = '{8'b00_00_00_00, 8'b11_11_00_00, 8'b11_00_00_00, 8'b11_00_00_00, 8'b11_00_00_11};
    at = '{5, 1, 1, 6, 1};
    for (int k = 0; k < 5; k++) begin
      cyc(at[k]);
      n_vec++;
      if ({btn_status, btn_press, btn_release, btn_hold} !== exp[k]) begin
        n_err++;
        $display("FAIL reset_release step %0d: got %b expected %b", k, {btn_status, btn_press, btn_release, btn_hold}, exp[k]);
      end
    end
  endtask
  task automatic test_clean_press();
    do_reset(2'b00);
    cyc(2);
    btn_in = 2'b01;
    cyc(5);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b00_00_00_00) begin
      n_err++;
      $display("FAIL press_edge5: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b0);
    end
    cyc(1);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_01_00_00) begin
      n_err++;
      $display("FAIL press_edge6: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_01_00_00);
    end
    cyc(1);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_00_00_00) begin
      n_err++;
      $display("FAIL press_edge7: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_00_00_00);
    end
  endtask
  task automatic test_bounce();
    do_reset(2'b00);
    cyc(2);
    btn_in = 2'b01;
    cyc(3);
    btn_in = 2'b00;
    cyc(1);
    btn_in = 2'b01;
    for (int k = 5; k < 10; k++) begin
      cyc(1);
      n_vec++;
      if ({btn_status, btn_press} !== 4'b0000) begin
        n_err++;
        $display("FAIL bounce_edge%0d: got %b expected %b", k, {btn_status, btn_press}, 4'b0000);
      end
    end
    cyc(1);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_01_00_00) begin
      n_err++;
      $display("FAIL bounce_press: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_01_00_00);
    end
  endtask
  task automatic test_release_hold();
    cyc(7);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_00_00_00) begin
      n_err++;
      $display("FAIL hold_early: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_00_00_00);
    end
    cyc(1);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_00_00_01) begin
      n_err++;
      $display("FAIL hold_set: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_00_00_01);
    end
    btn_in = 2'b00;
    cyc(3);
    btn_in = 2'b01;
    for (int k = 0; k < 8; k++) begin
      cyc(1);
      n_vec++;
      if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_00_00_01) begin
        n_err++;
        $display("FAIL glitch_low %0d: got %b expected %b", k, {btn_status, btn_press, btn_release, btn_hold}, 8'b01_00_00_01);
      end
    end
    btn_in = 2'b00;
    cyc(5);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_00_00_01) begin
      n_err++;
      $display("FAIL release_early: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_00_00_01);
    end
    cyc(1);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b00_00_01_00) begin
      n_err++;
      $display("FAIL release_edge: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b00_00_01_00);
    end
    cyc(1);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b00_00_00_00) begin
      n_err++;
      $display("FAIL release_pulse: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b0);
    end
  endtask
  task automatic test_async_reset();
    btn_in = 2'b01;
    cyc(6);
    cyc(8);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_00_00_01) begin
      n_err++;
      $display("FAIL pre_reset_hold: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_00_00_01);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b00_00_00_00) begin
      n_err++;
      $display("FAIL async_clear: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(5);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b00_00_00_00) begin
      n_err++;
      $display("FAIL rearm_edge5: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b0);
    end
    cyc(1);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_01_00_00) begin
      n_err++;
      $display("FAIL rearm_press: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_01_00_00);
    end
    cyc(7);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_00_00_00) begin
      n_err++;
      $display("FAIL rearm_hold_early: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_00_00_00);
    end
    cyc(1);
    n_vec++;
    if ({btn_status, btn_press, btn_release, btn_hold} !== 8'b01_00_00_01) begin
      n_err++;
      $display("FAIL rearm_hold: got %b expected %b", {btn_status, btn_press, btn_release, btn_hold}, 8'b01_00_00_01);
    end
  endtask
  task automatic model_step();
    logic s, old;
    for (int c = 0; c < 2; c++) begin
      s = m_s1[c];
      old = m_st[c];
      m_s1[c] = m_s0[c];
      m_s0[c] = btn_in[c];
      if (s == old) m_run[c] = 0;
      else if (m_run[c] == SC - 1) begin
        m_st[c] = ~old;
        m_run[c] = 0;
      end else m_run[c]++;
      m_pr[c] = m_st[c] & ~old;
      m_rl[c] = ~m_st[c] & old;
      if (!m_st[c]) begin
        m_hc[c] = 0;
        m_hold[c] = 1'b0;
      end else if (old && !m_hold[c]) begin
        if (m_hc[c] == HC - 1) m_hold[c] = 1'b1;
        else m_hc[c]++;
      end
    end
  endtask
  task automatic test_independence();
    int runs [14] = '{3, 1, 2, 4, 7, 1, 3, 16, 2, 5, 15, 3, 1, 9};
    logic lvl;
    do_reset(2'b10);
    {m_s0, m_s1, m_st, m_pr, m_rl, m_hold} = '0;
    m_run = '{0, 0};
    m_hc = '{0, 0};
    lvl = 1'b0;
    foreach (runs[r]) begin
      for (int j = 0; j < runs[r]; j++) begin
        btn_in = {~lvl, lvl};
        @(posedge clk);
        model_step();
        #1;
        n_vec++;
        if ({btn_status, btn_press, btn_release, btn_hold} !== {m_st, m_pr, m_rl, m_hold}) begin
          n_err++;
          $display("FAIL indep run %0d cyc %0d: got %b expected %b", r, j, {btn_status, btn_press, btn_release, btn_hold}, {m_st, m_pr, m_rl, m_hold});
        end
        n_vec++;
        if ((btn_press & btn_release) !== 2'b00) begin
          n_err++;
          $display("FAIL press_and_release run %0d cyc %0d: got %b expected %b", r, j, btn_press & btn_release, 2'b00);
        end
      end
      lvl = ~lvl;
    end
  endtask
  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_hold();
    test_async_reset();
    test_independence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
